traffic_sensor_requester: RTL and testbench
===========================================

// Module: traffic_sensor_requester
// PURPOSE
// - Side-road vehicle detector; drives the controller's sensor input.
// - Its other input is the controller's main-road light code.
// - Debounces a raw loop-detector line, counts queued vehicles, and raises sensor while any wait.
// - Drains the queue while the side road is served (main light RED).
// - Flags waits that exceed a limit.
// PARAMETERS
// - DEBOUNCE_CYCLES  4     consecutive equal synced samples needed to change the filtered level
// - SERVE_CYCLES     8     cycles of service per departing vehicle
// - CNT_W            4     width of the vehicle queue counter
// - MAX_WAIT         1024  cycles a request may stay unserved before wait_timeout
// PORTS
// - clk           in   1      clock, rising edge
// - reset         in   1      synchronous, active-high reset
// - raw_det       in   1      asynchronous raw detector; 1 = vehicle over loop
// - light         in   2      main-road light: 00 RED, 01 YELLOW, 10 GREEN, 11 invalid
// - sensor        out  1      service request to controller; 1 = vehicles waiting
// - veh_count     out  CNT_W  queued vehicles
// - overflow      out  1      sticky: arrival lost at saturation
// - wait_timeout  out  1      sticky until served: request unserved > MAX_WAIT
// - light_err     out  1      registered: light == 11 last cycle
// BEHAVIOUR
// - Reset: one clock, synchronous, active-high. All outputs 0; sync FFs 0; filtered 0; timers 0; state IDLE.
//   Reset mid-service discards the queue.
// - Input path: raw_det goes through a 2-FF synchronizer to s2.
// - Debounce:
//   - Counter increments while s2 != filtered; it clears when s2 == filtered.
//   - On the edge where the count reaches DEBOUNCE_CYCLES, filtered <= s2 and the counter clears.
//   - Glitches shorter than DEBOUNCE_CYCLES have no effect.
// - Arrival: one-cycle pulse on the registered rising edge of filtered.
// - Latency: raw_det rises at edge N, stable -> veh_count/sensor update at edge N+DEBOUNCE_CYCLES+2.
// - Departure: a serve timer runs only in SERVING.
//   - Timer counts 0..SERVE_CYCLES-1; the wrap pulse is a departure.
//   - Timer clears on entry to SERVING and on any exit.
// - Count update (all widths CNT_W, unsigned):
//   - arrival only: +1, saturating at 2^CNT_W-1.
//   - Arrival while at max: count holds and overflow <= 1.
//   - departure only: -1 (never below 0).
//   - arrival and departure together: count unchanged.
// - sensor is registered from the next-state count != 0, so it changes on the same edge as veh_count.
// - FSM is evaluated on the next-state count:
//   - IDLE: count 0. Go to WAITING when count > 0 and light != RED; go to SERVING when count > 0 and light == RED.
//   - WAITING: go to SERVING when light == RED; go to IDLE when count == 0 (not reachable without service).
//   - SERVING: go to IDLE when count reaches 0; go to WAITING when light != RED (timer clears, partial service is lost).
//   - light == 11: treated as not-RED. light_err <= 1; the serve timer freezes (holds, no departure).
// - Wait timer:
//   - Counts cycles in WAITING; clears in IDLE and SERVING.
//   - Reaching MAX_WAIT sets wait_timeout.
//   - wait_timeout clears on entry to SERVING or on reset.
// STRUCTURE
// - Shared package traffic_pkg: light codes LIGHT_RED=2'b00, LIGHT_YELLOW=2'b01, LIGHT_GREEN=2'b10.
// - Shared package also holds the FSM state encoding (IDLE/WAITING/SERVING, 2 bits); the controller uses the same package.
// - One sub-module: sensor_debounce (synchronizer, debounce counter, rise pulse; parameter DEBOUNCE_CYCLES).
// - Counter, timers and FSM live in this module.
// TESTING (DEBOUNCE_CYCLES=4, SERVE_CYCLES=8, CNT_W=4, MAX_WAIT=64)
// - Reset and glitch:
//   - Assert reset 1 cycle -> all outputs 0.
//   - raw_det high 3 cycles, light=GREEN -> veh_count stays 0, sensor 0.
// - Single arrival:
//   - raw_det rises at edge N, held 10 cycles, light=GREEN -> veh_count=1 and sensor=1 at edge N+6.
// - Service drain:
//   - Three arrivals, then light=RED -> veh_count steps 3,2,1,0 every 8 cycles.
//   - sensor falls on the edge count hits 0; state IDLE.
// - Simultaneous:
//   - Count 2 in SERVING; arrival pulse on the departure edge -> count stays 2.
// - Saturation:
//   - 16 arrivals with light=GREEN -> veh_count=15, overflow=1.
//   - overflow stays 1 after the drain until reset.
// - Timeout and invalid light:
//   - 1 vehicle, light=GREEN 64 cycles -> wait_timeout=1; light=RED -> wait_timeout=0 next edge.
//   - light=11 mid-service -> light_err=1, serve timer holds, no departure.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light codes and requester FSM encoding for the traffic
// controller and its side-road sensor requester.
package traffic_pkg;

   localparam logic [1:0] LIGHT_RED     = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
   localparam logic [1:0] LIGHT_GREEN   = 2'b10;
   localparam logic [1:0] LIGHT_INVALID = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAITING = 2'b01,
      SERVING = 2'b10
   } req_state_e;

   function automatic logic is_red(input logic [1:0] l);
      return l == LIGHT_RED;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Loop-detector input path: 2-FF synchronizer, level debounce
// and a one-cycle pulse on each filtered rising edge.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic rise_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1_q, s2_q;
   logic          filt_q, filt_d, filt_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = s2_q;
         else cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= raw_i;
         s2_q       <= s1_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   assign rise_o = filt_q & ~filt_dly_q;

endmodule

// File: rtl/traffic_sensor_requester.sv
// Side-road vehicle queue: counts debounced arrivals, drains while the
// main road is RED, and raises the controller's sensor request.
module traffic_sensor_requester
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SERVE_CYCLES    = 8,
   parameter int CNT_W           = 4,
   parameter int MAX_WAIT        = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             raw_det,
   input  logic [1:0]       light,
   output logic             sensor,
   output logic [CNT_W-1:0] veh_count,
   output logic             overflow,
   output logic             wait_timeout,
   output logic             light_err
);

   localparam int TW = $clog2(SERVE_CYCLES);
   localparam int WW = $clog2(MAX_WAIT + 1);

   req_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             ovf_q, ovf_d;
   logic             wto_q, wto_d;
   logic             sensor_q, lerr_q;
   logic             arrive, depart, red, bad, run;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw_det),
      .rise_o (arrive)
   );

   assign red    = is_red(light);
   assign bad    = (light == LIGHT_INVALID);
   assign run    = (state_q == SERVING) && red;
   assign depart = run && (tmr_q == TW'(SERVE_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (arrive && !depart) begin
         if (&cnt_q) ovf_d = 1'b1;
         else cnt_d = cnt_q + 1'b1;
      end else if (depart && !arrive && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // An invalid light code freezes service in place instead of ending it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (cnt_d != '0) state_d = red ? SERVING : WAITING;
         WAITING:
            if (cnt_d == '0) state_d = IDLE;
            else if (red)    state_d = SERVING;
         SERVING:
            if (cnt_d == '0)      state_d = IDLE;
            else if (!red && !bad) state_d = WAITING;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tmr_d = '0;
      if (state_q == SERVING && state_d == SERVING) begin
         if (depart)   tmr_d = '0;
         else if (run) tmr_d = tmr_q + 1'b1;
         else          tmr_d = tmr_q;
      end
      wait_d = '0;
      if (state_q == WAITING)
         wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
      wto_d = wto_q;
      if (state_q != SERVING && state_d == SERVING) wto_d = 1'b0;
      else if (wait_d == WW'(MAX_WAIT))             wto_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tmr_q    <= '0;
         wait_q   <= '0;
         ovf_q    <= 1'b0;
         wto_q    <= 1'b0;
         sensor_q <= 1'b0;
         lerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         wait_q   <= wait_d;
         ovf_q    <= ovf_d;
         wto_q    <= wto_d;
         sensor_q <= (cnt_d != '0);
         lerr_q   <= bad;
      end
   end

   assign sensor       = sensor_q;
   assign veh_count    = cnt_q;
   assign overflow     = ovf_q;
   assign wait_timeout = wto_q;
   assign light_err    = lerr_q;

endmodule

// File: tb/tb_traffic_sensor_requester.sv
// Scoreboard bench: stimulus schedules expected values per clock edge,
// a negedge monitor compares whatever falls due.
module tb_traffic_sensor_requester;

   localparam logic [1:0] RED   = 2'b00;
   localparam logic [1:0] GREEN = 2'b10;
   localparam logic [1:0] BAD   = 2'b11;

   localparam int S_CNT  = 0;
   localparam int S_SEN  = 1;
   localparam int S_OVF  = 2;
   localparam int S_WTO  = 3;
   localparam int S_LERR = 4;

   typedef struct {
      int    cyc;
      int    sig;
      int    val;
      string name;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       raw_det;
   logic [1:0] light;
   logic       sensor;
   logic [3:0] veh_count;
   logic       overflow;
   logic       wait_timeout;
   logic       light_err;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   traffic_sensor_requester #(
      .DEBOUNCE_CYCLES(4),
      .SERVE_CYCLES   (8),
      .CNT_W          (4),
      .MAX_WAIT       (64)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .raw_det      (raw_det),
      .light        (light),
      .sensor       (sensor),
      .veh_count    (veh_count),
      .overflow     (overflow),
      .wait_timeout (wait_timeout),
      .light_err    (light_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input string n, input int sig,
                                input int val, input int at);
      exp_t e;
      int   i;
      e.cyc  = at;
      e.sig  = sig;
      e.val  = val;
      e.name = n;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > at) i--;
      sb.insert(i, e);
   endfunction

   function automatic void push_all(input string n, input int at,
      input int c, input int s, input int o, input int w, input int l);
      push({n, "_cnt"}, S_CNT, c, at);
      push({n, "_sen"}, S_SEN, s, at);
      push({n, "_ovf"}, S_OVF, o, at);
      push({n, "_wto"}, S_WTO, w, at);
      push({n, "_lerr"}, S_LERR, l, at);
   endfunction

   function automatic int actual(input int sig);
      case (sig)
         S_CNT:   return int'(veh_count);
         S_SEN:   return int'(sensor);
         S_OVF:   return int'(overflow);
         S_WTO:   return int'(wait_timeout);
         default: return int'(light_err);
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      int   act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e   = sb.pop_front();
         act = actual(e.sig);
         tests++;
         if (e.cyc != cyc || act != e.val) begin
            fails++;
            $display("FAIL %s cyc %0d (due %0d): got %0d want %0d",
                     e.name, cyc, e.cyc, act, e.val);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Clean pulse: arrival counted 7 edges after the edge preceding raw rise
   task automatic arrive(input int k, output int e);
      e = cyc + 7;
      push("arr_cnt", S_CNT, k, e);
      push("arr_sen", S_SEN, 1, e);
      raw_det = 1'b1;
      step(6);
      raw_det = 1'b0;
      step(8);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: cyc %0d reached time limit", cyc);
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : stim
      int n, e, m;
      raw_det = 1'b0;
      light   = GREEN;
      reset   = 1'b1;
      step(1);
      reset = 1'b0;
      push_all("reset", cyc, 0, 0, 0, 0, 0);

      // 3-cycle glitch must not register
      step(2);
      n = cyc;
      push("glitch_cnt", S_CNT, 0, n + 7);
      push("glitch_sen", S_SEN, 0, n + 7);
      raw_det = 1'b1;
      step(3);
      raw_det = 1'b0;
      step(10);
      push("glitch_cnt2", S_CNT, 0, cyc);

      // single arrival latency, then wait timeout and its clear
      n = cyc;
      e = n + 7;
      push("lat_cnt0", S_CNT, 0, e - 1);
      push("lat_sen0", S_SEN, 0, e - 1);
      push("lat_cnt1", S_CNT, 1, e);
      push("lat_sen1", S_SEN, 1, e);
      push("wto_pre", S_WTO, 0, e + 63);
      push("wto_set", S_WTO, 1, e + 64);
      raw_det = 1'b1;
      step(10);
      raw_det = 1'b0;
      wait_until(e + 66);
      m = cyc;
      light = RED;
      push("wto_hold", S_WTO, 1, m);
      push("wto_clr", S_WTO, 0, m + 1);
      push("one_cnt1", S_CNT, 1, m + 8);
      push("one_cnt0", S_CNT, 0, m + 9);
      push("one_sen0", S_SEN, 0, m + 9);
      wait_until(m + 12);

      // three arrivals, drain 3,2,1,0 every 8 cycles
      light = GREEN;
      for (int k = 1; k <= 3; k++) arrive(k, e);
      m = cyc;
      light = RED;
      push("drn_3", S_CNT, 3, m + 8);
      push("drn_2", S_CNT, 2, m + 9);
      push("drn_2b", S_CNT, 2, m + 16);
      push("drn_1", S_CNT, 1, m + 17);
      push("drn_1b", S_CNT, 1, m + 24);
      push("drn_sen1", S_SEN, 1, m + 24);
      push("drn_0", S_CNT, 0, m + 25);
      push("drn_sen0", S_SEN, 0, m + 25);
      wait_until(m + 28);

      // arrival on a departure edge leaves the count unchanged
      light = GREEN;
      for (int k = 1; k <= 3; k++) arrive(k, e);
      m = cyc;
      light = RED;
      push("sim_2", S_CNT, 2, m + 9);
      push("sim_pre", S_CNT, 2, m + 16);
      push("sim_hit", S_CNT, 2, m + 17);
      push("sim_post", S_CNT, 2, m + 18);
      push("sim_1", S_CNT, 1, m + 25);
      push("sim_0", S_CNT, 0, m + 33);
      wait_until(m + 10);
      raw_det = 1'b1;
      step(6);
      raw_det = 1'b0;
      wait_until(m + 36);

      // invalid light mid-service freezes the serve timer
      n = cyc;
      e = n + 7;
      push("inv_cnt", S_CNT, 1, e);
      push("inv_lerr0", S_LERR, 0, e + 3);
      push("inv_lerr1", S_LERR, 1, e + 4);
      push("inv_hold", S_CNT, 1, e + 8);
      push("inv_lerr1b", S_LERR, 1, e + 8);
      push("inv_lerr2", S_LERR, 0, e + 9);
      push("inv_late1", S_CNT, 1, e + 12);
      push("inv_late0", S_CNT, 0, e + 13);
      raw_det = 1'b1;
      wait_until(e + 3);
      raw_det = 1'b0;
      light = BAD;
      wait_until(e + 8);
      light = RED;
      wait_until(e + 16);

      // saturation: 16th arrival is lost and overflow sticks
      light = GREEN;
      for (int k = 1; k <= 15; k++) arrive(k, e);
      push("sat_ovf0", S_OVF, 0, cyc + 6);
      push("sat_ovf1", S_OVF, 1, cyc + 7);
      arrive(15, e);
      m = cyc;
      light = RED;
      push("sat_wto1", S_WTO, 1, m);
      push("sat_wto0", S_WTO, 0, m + 1);
      push("sat_14", S_CNT, 14, m + 9);
      push("sat_c1", S_CNT, 1, m + 120);
      push("sat_c0", S_CNT, 0, m + 121);
      push("sat_sen0", S_SEN, 0, m + 121);
      push("sat_ovfk", S_OVF, 1, m + 125);
      wait_until(m + 126);

      reset = 1'b1;
      step(1);
      reset = 1'b0;
      push_all("rst2", cyc, 0, 0, 0, 0, 0);
      step(4);

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
